// File: rtl/taxi_stats_accum_if.sv
// ----------------------------------------------------------------------------
// taxi_axis_if
// AXI4-Stream style bundle carrying the statistics increment stream.
//   tdata  : payload (increment value)
//   tkeep  : byte enables (carried, unused by the accumulator)
//   tvalid : beat valid, driven by source
//   tready : beat accepted, driven by sink
//   tlast  : end of packet (carried, unused by the accumulator)
//   tid    : statistic identifier
//   tdest  : routing field (carried, unused by the accumulator)
//   tuser  : sideband; bit 0 marks a string fragment when USER_EN != 0
// Modports: src (master side) and snk (slave side).
// ----------------------------------------------------------------------------
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter int ID_W    = 8,
    parameter int DEST_W  = 8,
    parameter int USER_EN = 0,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_stats_accum.sv
// ----------------------------------------------------------------------------
// taxi_stats_accum
// Adds each increment beat of the statistics stream into a wide counter held
// in a single-port RAM, and serves host reads of those counters (optionally
// clearing the counter on read). One FSM owns the RAM port, so stream updates
// and host reads are strictly serialized and never overlap.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis_stat    : increment stream sink (tdata = increment, tid = stat id,
//                    tuser[0] = string fragment when USER_EN)
//   rd_req_addr    : host counter index
//   rd_req_valid   : host read request
//   rd_req_ready   : host request accepted on valid && ready
//   rd_resp_data   : counter value, qualified by rd_resp_valid
//   rd_resp_valid  : one-cycle response strobe, no backpressure
//   init_done      : RAM clear sweep finished
//   drop           : one-cycle pulse after a beat with out-of-range tid
// ----------------------------------------------------------------------------
module taxi_stats_accum #(
    parameter int CNT         = 32,
    parameter int ID_BASE     = 0,
    parameter int STAT_W      = 64,
    parameter int CLR_ON_READ = 0,
    localparam int ADDR_W     = (CNT > 1) ? $clog2(CNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    taxi_axis_if.snk          s_axis_stat,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    output logic [STAT_W-1:0] rd_resp_data,
    output logic              rd_resp_valid,
    output logic              init_done,
    output logic              drop
);
    localparam int ID_W       = $bits(s_axis_stat.tid);
    localparam int AXIS_USER  = s_axis_stat.USER_EN;

    localparam logic [ID_W:0]       BASE_EXT = (ID_W + 1)'(ID_BASE);
    localparam logic [31:0]         CNT_U    = 32'(CNT);
    localparam logic [ADDR_W-1:0]   LAST_PTR = ADDR_W'(CNT - 1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ACC_RD   = 3'd2,
        ST_ACC_WR   = 3'd3,
        ST_HOST_RD  = 3'd4,
        ST_HOST_RSP = 3'd5
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   init_ptr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [STAT_W-1:0]   inc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_oor_q;
    logic                last_host_q;
    logic                init_done_q;
    logic                drop_q;
    logic                rsp_valid_q;

    logic [STAT_W-1:0]   mem [CNT];
    logic [STAT_W-1:0]   ram_rd_q;

    logic                grant_stream_s;
    logic                grant_host_s;
    logic [ID_W:0]       idx_full_s;
    logic                idx_oor_s;
    logic                is_str_s;
    logic                req_oor_s;
    logic                ram_we_s;
    logic                ram_re_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [STAT_W-1:0]   ram_wdata_s;

    // One extra bit so that tid < ID_BASE shows up as a set MSB instead of
    // wrapping into a valid-looking index.
    assign idx_full_s = {1'b0, s_axis_stat.tid} - BASE_EXT;
    assign idx_oor_s  = ({1'b0, s_axis_stat.tid} < BASE_EXT) || (32'(idx_full_s) >= CNT_U);
    assign is_str_s   = (AXIS_USER != 0) && s_axis_stat.tuser[0];
    assign req_oor_s  = 32'(rd_req_addr) >= CNT_U;

    // Arbitrate stream vs host in IDLE; on contention, serve whoever lost last time.
    always_comb begin
        grant_stream_s = 1'b0;
        grant_host_s   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (s_axis_stat.tvalid && rd_req_valid) begin
                grant_stream_s = last_host_q;
                grant_host_s   = !last_host_q;
            end else begin
                grant_stream_s = s_axis_stat.tvalid;
                grant_host_s   = rd_req_valid;
            end
        end else begin
            grant_stream_s = 1'b0;
            grant_host_s   = 1'b0;
        end
    end

    assign s_axis_stat.tready = grant_stream_s;
    assign rd_req_ready       = grant_host_s;

    // Drive the single RAM port from the current FSM state.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        case (state_q)
            ST_INIT: begin
                ram_we_s   = 1'b1;
                ram_addr_s = init_ptr_q;
            end
            ST_ACC_RD: begin
                ram_re_s   = 1'b1;
                ram_addr_s = idx_q;
            end
            ST_ACC_WR: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = idx_q;
                ram_wdata_s = ram_rd_q + inc_q;
            end
            ST_HOST_RD: begin
                ram_re_s   = !addr_oor_q;
                ram_addr_s = addr_q;
            end
            ST_HOST_RSP: begin
                ram_we_s   = (CLR_ON_READ != 0) && !addr_oor_q;
                ram_addr_s = addr_q;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Counter storage with registered read data (no reset on the array).
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_addr_s] <= ram_wdata_s;
        end
        if (ram_re_s) begin
            ram_rd_q <= mem[ram_addr_s];
        end
    end

    // Main control FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            idx_q       <= '0;
            inc_q       <= '0;
            addr_q      <= '0;
            addr_oor_q  <= 1'b0;
            last_host_q <= 1'b0;
            init_done_q <= 1'b0;
            drop_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            drop_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + ADDR_W'(1);
                    if (init_ptr_q == LAST_PTR) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (grant_stream_s) begin
                        last_host_q <= 1'b0;
                        if (idx_oor_s) begin
                            drop_q <= 1'b1;
                        end else if (is_str_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= ADDR_W'(idx_full_s);
                            inc_q   <= STAT_W'(s_axis_stat.tdata);
                            state_q <= ST_ACC_RD;
                        end
                    end else if (grant_host_s) begin
                        last_host_q <= 1'b1;
                        addr_q      <= rd_req_addr;
                        addr_oor_q  <= req_oor_s;
                        state_q     <= ST_HOST_RD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC_RD:   state_q <= ST_ACC_WR;
                ST_ACC_WR:   state_q <= ST_IDLE;
                ST_HOST_RD: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_HOST_RSP;
                end
                ST_HOST_RSP: state_q <= ST_IDLE;
                default: begin
                    state_q    <= ST_INIT;
                    init_ptr_q <= '0;
                end
            endcase
        end
    end

    // Response data only exists while the read register holds the host's word;
    // gating by state keeps it zero in reset and for out-of-range addresses.
    assign rd_resp_data  = (state_q == ST_HOST_RSP && !addr_oor_q) ? ram_rd_q : '0;
    assign rd_resp_valid = rsp_valid_q;
    assign init_done     = init_done_q;
    assign drop          = drop_q;
endmodule

// File: tb/tb_taxi_stats_accum.sv
// ----------------------------------------------------------------------------
// tb_taxi_stats_accum
// Directed bench. dut_a: CNT=4, ID_BASE=4, STAT_W=16, clear-on-read, USER_EN.
// dut_b: CNT=4, ID_BASE=0, STAT_W=64, no clear-on-read, no USER_EN.
// Inputs are driven on the falling edge, outputs sampled 1-2 time units later.
// ----------------------------------------------------------------------------
module tb_taxi_stats_accum;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(16), .ID_W(4), .DEST_W(1), .USER_EN(1), .USER_W(1)) a_axis ();
    logic [1:0]  a_rd_addr;
    logic        a_rd_valid, a_rd_ready, a_rsp_valid, a_init_done, a_drop;
    logic [15:0] a_rsp_data;

    taxi_stats_accum #(.CNT(4), .ID_BASE(4), .STAT_W(16), .CLR_ON_READ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis_stat(a_axis),
        .rd_req_addr(a_rd_addr), .rd_req_valid(a_rd_valid), .rd_req_ready(a_rd_ready),
        .rd_resp_data(a_rsp_data), .rd_resp_valid(a_rsp_valid),
        .init_done(a_init_done), .drop(a_drop)
    );

    taxi_axis_if #(.DATA_W(32), .ID_W(3), .DEST_W(1), .USER_EN(0), .USER_W(1)) b_axis ();
    logic [1:0]  b_rd_addr;
    logic        b_rd_valid, b_rd_ready, b_rsp_valid, b_init_done, b_drop;
    logic [63:0] b_rsp_data;

    taxi_stats_accum #(.CNT(4), .ID_BASE(0), .STAT_W(64), .CLR_ON_READ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis_stat(b_axis),
        .rd_req_addr(b_rd_addr), .rd_req_valid(b_rd_valid), .rd_req_ready(b_rd_ready),
        .rd_resp_data(b_rsp_data), .rd_resp_valid(b_rsp_valid),
        .init_done(b_init_done), .drop(b_drop)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat to dut_a; returns at the falling edge after acceptance.
    task automatic a_send(input logic [3:0] tid, input logic [15:0] d, input logic u, output int w);
        w = 0;
        a_axis.tvalid = 1'b1;
        a_axis.tid    = tid;
        a_axis.tdata  = d;
        a_axis.tuser  = u;
        #1;
        while (a_axis.tready !== 1'b1 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("a_send_accept", 64'(w < 40), 64'd1);
        @(negedge clk);
        a_axis.tvalid = 1'b0;
    endtask

    // Host read on dut_a: response must be exactly two cycles after acceptance.
    task automatic a_read(input string tag, input logic [1:0] addr, input logic [15:0] exp, output int w);
        logic [2:0] v;
        w = 0;
        a_rd_valid = 1'b1;
        a_rd_addr  = addr;
        #1;
        while (a_rd_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_accept"}, 64'(w < 40), 64'd1);
        @(negedge clk);
        a_rd_valid = 1'b0;
        #1;
        v[2] = a_rsp_valid;
        @(negedge clk);
        #1;
        v[1] = a_rsp_valid;
        check({tag, "_data"}, 64'(a_rsp_data), 64'(exp));
        @(negedge clk);
        #1;
        v[0] = a_rsp_valid;
        check({tag, "_vld_timing"}, 64'(v), 64'd2);
    endtask

    task automatic b_send(input logic [2:0] tid, input logic [31:0] d, input logic u);
        int w = 0;
        b_axis.tvalid = 1'b1;
        b_axis.tid    = tid;
        b_axis.tdata  = d;
        b_axis.tuser  = u;
        #1;
        while (b_axis.tready !== 1'b1 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("b_send_accept", 64'(w < 40), 64'd1);
        @(negedge clk);
        b_axis.tvalid = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [1:0] addr, input logic [63:0] exp);
        int w = 0;
        b_rd_valid = 1'b1;
        b_rd_addr  = addr;
        #1;
        while (b_rd_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_accept"}, 64'(w < 40), 64'd1);
        @(negedge clk);
        b_rd_valid = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_vld"}, 64'(b_rsp_valid), 64'd1);
        check({tag, "_data"}, b_rsp_data, exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [3:0]  p;
        logic [11:0] tr, hr, rv;

        rst_n         = 1'b0;
        a_axis.tvalid = 1'b1;
        a_axis.tid    = 4'd3;
        a_axis.tdata  = 16'd0;
        a_axis.tuser  = 1'b0;
        a_axis.tkeep  = 2'b11;
        a_axis.tlast  = 1'b0;
        a_axis.tdest  = 1'b0;
        a_rd_valid    = 1'b0;
        a_rd_addr     = 2'd0;
        b_axis.tvalid = 1'b0;
        b_axis.tid    = 3'd0;
        b_axis.tdata  = 32'd0;
        b_axis.tuser  = 1'b0;
        b_axis.tkeep  = 4'hF;
        b_axis.tlast  = 1'b0;
        b_axis.tdest  = 1'b0;
        b_rd_valid    = 1'b0;
        b_rd_addr     = 2'd0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready",    64'(a_axis.tready), 64'd0);
        check("rst_rd_ready",  64'(a_rd_ready),    64'd0);
        check("rst_rsp_valid", 64'(a_rsp_valid),   64'd0);
        check("rst_rsp_data",  64'(a_rsp_data),    64'd0);
        check("rst_drop",      64'(a_drop),        64'd0);
        check("rst_init_done", 64'(a_init_done),   64'd0);

        // INIT sweep: tready low for 4 cycles with tvalid held, init_done in cycle 4
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("init_tready", 64'(a_axis.tready), 64'd0);
            check("init_done_low", 64'(a_init_done), 64'd0);
            @(negedge clk);
        end
        #1;
        check("init_tready_c4", 64'(a_axis.tready), 64'd1);
        check("init_done_c4",   64'(a_init_done),   64'd1);
        @(negedge clk);
        a_axis.tvalid = 1'b0;
        #1;
        check("init_beat_drop", 64'(a_drop), 64'd1);
        @(negedge clk);
        #1;
        check("init_drop_pulse_end", 64'(a_drop), 64'd0);

        for (int k = 0; k < 4; k++) begin
            a_read("init_rd", 2'(k), 16'd0, w);
        end

        // Accumulate: two beats to counter 2 (tid 6), tready pattern 1,0,0,1
        @(negedge clk);
        a_axis.tvalid = 1'b1;
        a_axis.tid    = 4'd6;
        a_axis.tdata  = 16'd5;
        a_axis.tuser  = 1'b0;
        #1;
        p[0] = a_axis.tready;
        @(negedge clk);
        a_axis.tdata = 16'd7;
        #1;
        p[1] = a_axis.tready;
        @(negedge clk);
        #1;
        p[2] = a_axis.tready;
        @(negedge clk);
        #1;
        p[3] = a_axis.tready;
        @(negedge clk);
        a_axis.tvalid = 1'b0;
        check("acc_tready_pattern", 64'(p), 64'h9);
        a_read("acc_rd2", 2'd2, 16'd12, w);

        // Wrap modulo 2^16 on counter 1 (tid 5)
        a_send(4'd5, 16'hFFFF, 1'b0, w);
        a_send(4'd5, 16'h0002, 1'b0, w);
        a_read("wrap_rd1", 2'd1, 16'h0001, w);

        // Out-of-range and string beats leave counters untouched
        a_send(4'd4, 16'd3, 1'b0, w);
        a_send(4'd3, 16'h00AA, 1'b0, w);
        #1;
        check("drop_tid3", 64'(a_drop), 64'd1);
        a_send(4'd8, 16'h00BB, 1'b0, w);
        check("drop_back_to_back", 64'(w), 64'd0);
        #1;
        check("drop_tid8", 64'(a_drop), 64'd1);
        @(negedge clk);
        #1;
        check("drop_end", 64'(a_drop), 64'd0);
        a_send(4'd5, 16'h0055, 1'b1, w);
        #1;
        check("str_no_drop", 64'(a_drop), 64'd0);
        a_read("str_rd1", 2'd1, 16'd0, w);
        check("str_no_stall", 64'(w), 64'd0);
        a_read("oor_rd0", 2'd0, 16'd3, w);
        a_read("oor_rd3", 2'd3, 16'd0, w);
        a_read("oor_rd2", 2'd2, 16'd0, w);

        // Arbitration: both continuously valid, last winner was the host
        a_axis.tvalid = 1'b1;
        a_axis.tid    = 4'd7;
        a_axis.tdata  = 16'd1;
        a_axis.tuser  = 1'b0;
        a_rd_valid    = 1'b1;
        a_rd_addr     = 2'd3;
        for (int i = 0; i < 12; i++) begin
            #1;
            tr[i] = a_axis.tready;
            hr[i] = a_rd_ready;
            rv[i] = a_rsp_valid;
            if (a_rsp_valid === 1'b1) begin
                check("arb_rsp_data", 64'(a_rsp_data), 64'd1);
            end
            @(negedge clk);
        end
        a_axis.tvalid = 1'b0;
        a_rd_valid    = 1'b0;
        check("arb_stream_grants", 64'(tr), 64'h041);
        check("arb_host_grants",   64'(hr), 64'h208);
        check("arb_rsp_strobes",   64'(rv), 64'h820);

        // Clear-on-read
        a_send(4'd6, 16'd9, 1'b0, w);
        a_read("cor_first",  2'd2, 16'd9, w);
        a_read("cor_second", 2'd2, 16'd0, w);

        // Asynchronous reset during ACC_WR of counter 0
        a_send(4'd4, 16'd20, 1'b0, w);
        a_send(4'd4, 16'd5, 1'b0, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_init_done", 64'(a_init_done), 64'd0);
        check("arst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("arst_init_c3", 64'(a_init_done), 64'd0);
        @(negedge clk);
        #1;
        check("arst_init_c4", 64'(a_init_done), 64'd1);
        a_read("arst_rd0", 2'd0, 16'd0, w);

        // dut_b: 64-bit counters, tuser ignored, no clear on read
        check("b_init_done", 64'(b_init_done), 64'd1);
        b_send(3'd1, 32'h1234_5678, 1'b1);
        b_send(3'd1, 32'h9ABC_DEF0, 1'b0);
        b_send(3'd2, 32'hFFFF_FFFF, 1'b0);
        b_send(3'd2, 32'hFFFF_FFFF, 1'b0);
        b_send(3'd5, 32'h0000_0001, 1'b0);
        #1;
        check("b_drop_tid5", 64'(b_drop), 64'd1);
        b_read("b_rd1_first",  2'd1, 64'h0000_0000_ACF1_3568);
        b_read("b_rd1_second", 2'd1, 64'h0000_0000_ACF1_3568);
        b_read("b_rd2_carry",  2'd2, 64'h0000_0001_FFFF_FFFE);
        b_read("b_rd3_zero",   2'd3, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
